// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core front end.
//   ADDR_W        - address/data width of the core
//   RESET_PC_DEF  - default fetch address after reset release
//   NOP_INSTR_DEF - encoding loaded into the IF/ID register on flush/bubble
//   fetch_state_t - instruction fetch FSM states
package mips_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] WORD_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a fetch request
    S_WAIT = 2'd1,  // request accepted, waiting for data
    S_HOLD = 2'd2   // data returned while ID stalled, parked in hold buffer
  } fetch_state_t;

  // Sequential instruction address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - capture instr_in/pc_in, mark valid
//   flush        - invalidate and replace instruction with NOP (pc kept)
//   (neither)    - hold all fields
//   instr_in     - instruction to load
//   pc_in        - PC of instr_in
//   instr_d      - registered instruction
//   pc_d         - registered PC
//   pc_plus4_d   - registered PC + 4
//   valid_d      - registered instruction is real
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [ADDR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] instr_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (load) begin
      instr_d    <= instr_in;
      pc_d       <= pc_in;
      pc_plus4_d <= next_word(pc_in);
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with IF/ID register.
// One outstanding request on a req/addr_ok/data_ok memory handshake.
//   clk, rst_n     - clock, asynchronous active-low reset
//   stall_d        - ID stalled; IF/ID holds
//   redirect       - branch/jump resolved in ID this cycle
//   redirect_pc    - new fetch target (low two bits ignored)
//   inst_req       - fetch request valid
//   inst_addr      - word-aligned fetch address
//   inst_addr_ok   - memory accepted the request
//   inst_rdata     - returned instruction
//   inst_data_ok   - inst_rdata valid
//   instr_d        - IF/ID instruction
//   pc_d           - PC of instr_d
//   pc_plus4_d     - pc_d + 4
//   valid_d        - instr_d is a real instruction
//   fetch_busy     - request outstanding
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_d,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [ADDR_W-1:0] inst_rdata,
  input  logic              inst_data_ok,
  output logic [ADDR_W-1:0] instr_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic              fetch_busy
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] hold_instr;
  logic              hold_valid;
  logic              discard;

  logic              take_redirect;
  logic              accept;
  logic              deliver_wait;
  logic              deliver_hold;
  logic              ifid_load;
  logic              ifid_flush;
  logic [ADDR_W-1:0] ifid_instr;

  assign inst_addr = pc_f & WORD_MASK;

  // A stall masks redirect entirely for that cycle.
  assign take_redirect = redirect && !stall_d;
  // inst_req is registered low for the first cycle after reset, so an
  // addr_ok then is not a real grant.
  assign accept        = (state_q == S_REQ) && inst_req && inst_addr_ok;

  always_comb begin
    deliver_wait = (state_q == S_WAIT) && inst_data_ok && !discard;
    deliver_hold = (state_q == S_HOLD) && hold_valid;
    ifid_load    = !stall_d && !redirect && (deliver_wait || deliver_hold);
    // Redirect flush and plain bubble have the same effect on IF/ID.
    ifid_flush   = !stall_d && !ifid_load;
    ifid_instr   = deliver_hold ? hold_instr : inst_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_f        <= RESET_PC;
      inflight_pc <= '0;
      hold_instr  <= '0;
      hold_valid  <= 1'b0;
      discard     <= 1'b0;
      inst_req    <= 1'b0;
      fetch_busy  <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            inflight_pc <= inst_addr;
            // A redirect in the issuing cycle leaves the old request in
            // flight; its data must be dropped.
            discard     <= take_redirect;
            inst_req    <= 1'b0;
            fetch_busy  <= 1'b1;
            state_q     <= S_WAIT;
          end else begin
            inst_req <= 1'b1;
          end
          if (take_redirect) pc_f <= redirect_pc;
        end

        S_WAIT: begin
          if (inst_data_ok) begin
            fetch_busy <= 1'b0;
            if (discard || take_redirect) begin
              discard  <= 1'b0;
              inst_req <= 1'b1;
              state_q  <= S_REQ;
            end else if (!stall_d) begin
              pc_f     <= next_word(inflight_pc);
              inst_req <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              hold_instr <= inst_rdata;
              hold_valid <= 1'b1;
              state_q    <= S_HOLD;
            end
          end else if (take_redirect) begin
            discard <= 1'b1;
          end
          if (take_redirect) pc_f <= redirect_pc;
        end

        S_HOLD: begin
          if (!stall_d) begin
            hold_valid <= 1'b0;
            inst_req   <= 1'b1;
            state_q    <= S_REQ;
            pc_f       <= take_redirect ? redirect_pc : next_word(inflight_pc);
          end
        end

        default: begin
          state_q    <= S_REQ;
          inst_req   <= 1'b0;
          fetch_busy <= 1'b0;
          hold_valid <= 1'b0;
          discard    <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .instr_in  (ifid_instr),
    .pc_in     (inflight_pc),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_busy;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec;
  int unsigned n_err;
  bit          no_update_q;

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_busy  (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // IF/ID monitor: a fresh valid_d after an edge without stall is a delivery.
  always @(posedge clk) begin
    no_update_q = stall_d || !rst_n;
    #1;
    if (rst_n && !no_update_q && valid_d) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, valid_d}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr_d", instr_d, e.instr);
        chk("pc_d", pc_d, e.pc);
        chk("pc_plus4_d", pc_plus4_d, e.pc + 32'd4);
      end
    end
  end

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (inst_req) break;
      tick();
    end
    chk("req_seen", {31'b0, inst_req}, 32'd1);
  endtask

  task automatic grant(input logic [31:0] a);
    wait_req();
    chk("inst_addr", inst_addr, a);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("busy", {31'b0, fetch_busy}, 32'd1);
    chk("req_in_wait", {31'b0, inst_req}, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input int unsigned lat, input bit deliver);
    grant(a);
    for (int unsigned i = 1; i < lat; i++) tick();
    if (deliver) sb.push_back('{d, a});
    inst_data_ok = 1'b1;
    inst_rdata   = d;
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, inst_req},   32'd0);
    chk({tag, "_busy"},  {31'b0, fetch_busy}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid_d},    32'd0);
    chk({tag, "_instr"}, instr_d,    NOP);
    chk({tag, "_pc"},    pc_d,       32'd0);
    chk({tag, "_pc4"},   pc_plus4_d, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall_d = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    inst_addr_ok = 1'b0;
    inst_rdata = '0;
    inst_data_ok = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Zero-wait fetch after reset, then sequential address.
    fetch(RST_PC, 32'h2408_0005, 1, 1'b1);
    chk("seq_addr", inst_addr, 32'hBFC0_0004);

    // Data returns during a 3-cycle stall: parked, then delivered.
    grant(32'hBFC0_0004);
    stall_d = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h8C09_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_data_ok = 1'b0;
      chk("hold_req", {31'b0, inst_req}, 32'd0);
      chk("hold_valid", {31'b0, valid_d}, 32'd0);
      chk("hold_instr", instr_d, NOP);
      chk("hold_pc", pc_d, RST_PC);
    end
    sb.push_back('{32'h8C09_0000, 32'hBFC0_0004});
    stall_d = 1'b0;
    tick();
    tick();
    chk("bubble_valid", {31'b0, valid_d}, 32'd0);

    // Redirect while waiting: returned word dropped.
    grant(32'hBFC0_0008);
    redirect = 1'b1;
    redirect_pc = 32'hBFC0_0100;
    tick();
    redirect = 1'b0;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    chk("drop_valid", {31'b0, valid_d}, 32'd0);
    fetch(32'hBFC0_0100, 32'h3C01_1234, 2, 1'b1);

    // Redirect with stall ignored; redirect alone takes effect, low bits cleared.
    stall_d = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hBFC0_0203;
    tick();
    chk("stall_redir_addr", inst_addr, 32'hBFC0_0104);
    chk("stall_redir_valid", {31'b0, valid_d}, 32'd1);
    stall_d = 1'b0;
    tick();
    redirect = 1'b0;
    chk("redir_addr", inst_addr, 32'hBFC0_0200);
    chk("redir_flush", {31'b0, valid_d}, 32'd0);

    // Redirect in the same cycle the request is accepted.
    inst_addr_ok = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hBFC0_0300;
    tick();
    inst_addr_ok = 1'b0;
    redirect = 1'b0;
    chk("acc_redir_busy", {31'b0, fetch_busy}, 32'd1);
    inst_data_ok = 1'b1;
    inst_rdata = 32'h1111_1111;
    tick();
    inst_data_ok = 1'b0;
    fetch(32'hBFC0_0300, 32'h2402_0001, 1, 1'b1);

    // Redirect out of the hold state drops the parked word.
    grant(32'hBFC0_0304);
    stall_d = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h2222_2222;
    tick();
    inst_data_ok = 1'b0;
    stall_d = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("hold_redir_valid", {31'b0, valid_d}, 32'd0);
    chk("hold_redir_req", {31'b0, inst_req}, 32'd1);

    // Top of address space wraps.
    fetch(32'hFFFF_FFFC, 32'h0000_0008, 3, 1'b1);
    chk("wrap_addr", inst_addr, 32'h0000_0000);

    // Reset while waiting; stale response after release ignored.
    grant(32'h0000_0000);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata = 32'h3333_3333;
    tick();
    inst_data_ok = 1'b0;
    chk("stale_valid", {31'b0, valid_d}, 32'd0);
    chk("restart_addr", inst_addr, RST_PC);
    fetch(RST_PC, 32'h2408_0005, 1, 1'b1);
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
